// File: rtl/clock_pkg.sv
// clock_pkg: shared time-of-day constants and load FSM states
package clock_pkg;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int MIN_W = 6;
    localparam int HOUR_W = 5;
    typedef enum logic [0:0] {RUN = 1'b0, APPLY = 1'b1} state_t;
endpackage

// File: rtl/min_hour_counter_if.sv
// min_hour_counter_if: valid/ready time-load port
interface min_hour_counter_if;
    import clock_pkg::*;
    logic load_valid;
    logic load_ready;
    logic [MIN_W-1:0] load_minutes;
    logic [HOUR_W-1:0] load_hours;
    logic load_error;
    modport master(output load_valid, load_minutes, load_hours, input load_ready, load_error);
    modport slave(input load_valid, load_minutes, load_hours, output load_ready, load_error);
endinterface

// File: rtl/mod_counter.sv
// mod_counter: loadable modulo counter with combinational wrap carry
module mod_counter #(
    parameter int MODULUS = 60,
    parameter int WIDTH = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic wrap
);
    // wrap is combinational so a chained counter steps in the same cycle
    assign wrap = inc && value == WIDTH'(MODULUS - 1);
    always_ff @(posedge clk) begin
        if (reset) value <= '0;
        else if (load) value <= load_value;
        else if (inc) value <= wrap ? '0 : value + WIDTH'(1);
    end
endmodule

// File: rtl/min_hour_counter.sv
// min_hour_counter: minutes/hours time-of-day with time load and minute alarm
module min_hour_counter
    import clock_pkg::*;
#(
    parameter int MAX_HOURS = 24,
    parameter bit ALARM_EN_RST = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sec_tick,
    min_hour_counter_if.slave load_port,
    input  logic alarm_set,
    input  logic alarm_clear,
    input  logic [MIN_W-1:0] alarm_minutes,
    input  logic [HOUR_W-1:0] alarm_hours,
    output logic [MIN_W-1:0] minutes,
    output logic [HOUR_W-1:0] hours,
    output logic min_rollover,
    output logic day_rollover,
    output logic alarm_hit,
    output logic alarm_armed
);
    state_t state;
    logic [MIN_W-1:0] ld_min, al_min, nxt_min;
    logic [HOUR_W-1:0] ld_hr, al_hr, nxt_hr;
    logic accept, apply, ok, inc, min_wrap, hr_wrap;
    assign load_port.load_ready = state == RUN;
    assign accept = load_port.load_valid && state == RUN;
    assign apply = state == APPLY;
    assign ok = ld_min <= MIN_W'(MIN_MAX) && ld_hr < HOUR_W'(MAX_HOURS);
    // a tick colliding with a load handshake is dropped; the load wins
    assign inc = state == RUN && sec_tick && !load_port.load_valid;
    assign nxt_min = min_wrap ? '0 : minutes + MIN_W'(1);
    assign nxt_hr = hr_wrap ? '0 : hours + HOUR_W'(min_wrap);
    mod_counter #(.MODULUS(60), .WIDTH(MIN_W)) u_min (
        .clk(clk), .reset(reset), .inc(inc), .load(apply && ok),
        .load_value(ld_min), .value(minutes), .wrap(min_wrap)
    );
    mod_counter #(.MODULUS(MAX_HOURS), .WIDTH(HOUR_W)) u_hr (
        .clk(clk), .reset(reset), .inc(min_wrap), .load(apply && ok),
        .load_value(ld_hr), .value(hours), .wrap(hr_wrap)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            ld_min <= '0;
            ld_hr <= '0;
            load_port.load_error <= 1'b0;
            min_rollover <= 1'b0;
            day_rollover <= 1'b0;
            alarm_hit <= 1'b0;
            alarm_armed <= ALARM_EN_RST;
            al_min <= '0;
            al_hr <= '0;
        end else begin
            state <= accept ? APPLY : RUN;
            if (accept) begin
                ld_min <= load_port.load_minutes;
                ld_hr <= load_port.load_hours;
            end
            load_port.load_error <= apply && !ok;
            min_rollover <= min_wrap;
            day_rollover <= hr_wrap;
            // only counted steps can hit; loads never reach this compare
            alarm_hit <= inc && alarm_armed && nxt_min == al_min && nxt_hr == al_hr;
            alarm_armed <= alarm_clear ? 1'b0 : alarm_set ? 1'b1 : alarm_armed;
            if (alarm_set) begin
                al_min <= alarm_minutes;
                al_hr <= alarm_hours;
            end
        end
    end
endmodule

// File: doc/min_hour_counter.md
Name: min_hour_counter

Overview:
Downstream stage of the seconds counter. Consumes its one-cycle `rollover` pulse as `sec_tick` and maintains minutes and hours of the time-of-day. Adds a valid/ready time-load port for setting the clock, plus a minute-resolution alarm. Emits carry pulses for the display and calendar logic further downstream.

Parameters:
- MAX_HOURS, 24: hour modulus; legal values 12 or 24; hours count 0..MAX_HOURS-1.
- ALARM_EN_RST, 0: reset value of the internal alarm-armed flag.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- sec_tick  in  1  one-cycle pulse from the seconds stage on the 59->0 wrap.
- load_valid  in  1  time-load request.
- load_ready  out  1  block can accept a load this cycle.
- load_minutes  in  6  requested minutes.
- load_hours  in  5  requested hours.
- load_error  out  1  one-cycle pulse: last accepted load was out of range and was discarded.
- alarm_set  in  1  one-cycle strobe: capture alarm_minutes/alarm_hours and arm the alarm.
- alarm_clear  in  1  one-cycle strobe: disarm the alarm.
- alarm_minutes  in  6  alarm minutes.
- alarm_hours  in  5  alarm hours.
- minutes  out  6  current minutes, 0..59.
- hours  out  5  current hours, 0..MAX_HOURS-1.
- min_rollover  out  1  one-cycle pulse when minutes wrap 59->0.
- day_rollover  out  1  one-cycle pulse when hours wrap MAX_HOURS-1->0.
- alarm_hit  out  1  one-cycle pulse when counting reaches the armed alarm time.
- alarm_armed  out  1  alarm-armed flag.

Behaviour:
- Reset:
  - minutes=0, hours=0.
  - min_rollover=0, day_rollover=0, load_error=0, alarm_hit=0.
  - alarm_armed=ALARM_EN_RST; alarm registers cleared to 0.
  - FSM=RUN.
  - Reset asserted mid-load aborts the load with no error pulse.
- FSM states:
  - RUN: load_ready=1. load_valid & load_ready -> capture load_minutes/load_hours, go to APPLY.
  - APPLY: lasts exactly 1 cycle; load_ready=0.
    - If minutes<=59 and hours<MAX_HOURS: write the values to the counters.
    - Otherwise: counters unchanged, load_error=1 for the following cycle.
    - Always returns to RUN.
- Counting, RUN only, on sec_tick=1 in cycle N; registered outputs update in cycle N+1:
  - minutes<59: minutes+1, pulses 0.
  - minutes==59: minutes=0, min_rollover=1.
    - If hours<MAX_HOURS-1: hours+1.
    - Otherwise: hours=0, day_rollover=1.
- All pulses are high for exactly one cycle and default to 0 otherwise.
- Simultaneous events:
  - sec_tick in the same cycle as a load handshake: tick discarded; the load overwrites the time.
  - sec_tick during APPLY: discarded.
- alarm_hit:
  - Asserted in the same cycle the counted value (not a loaded value) first equals the alarm registers, while alarm_armed=1.
  - A load landing on the alarm time does not fire it.
  - The alarm stays armed after a hit and fires again 24 h (or 12 h) later.
- Alarm strobes:
  - alarm_set and alarm_clear in the same cycle: clear wins, but the alarm registers still capture.
  - alarm_set values are not range-checked; an unreachable value never hits.
- Widths: all compares are unsigned. Increments are computed at register width; no overflow is possible within the legal ranges.

Decomposition:
- Shared package clock_pkg:
  - SEC_MAX=59, MIN_MAX=59.
  - MIN_W=6, HOUR_W=5.
  - FSM state enum {RUN, APPLY}.
  - Also used by the seconds stage and display.
- Sub-module mod_counter:
  - Parameters: modulus, width.
  - Ports: inc, load, load_value in; value, wrap pulse out.
  - Instantiated twice: minutes with modulus 60, hours with modulus MAX_HOURS; the hours inc is the minutes wrap.

Test Plan:
1. Reset, then 60 sec_tick pulses spaced 3 cycles -> minutes=0, hours=1; min_rollover pulsed once, 1 cycle after the 60th tick.
2. Load 23:59 (MAX_HOURS=24), then 1 sec_tick -> next cycle minutes=0, hours=0; min_rollover=1 and day_rollover=1 together for one cycle.
3. Load minutes=60, hours=5 -> load_ready low 1 cycle, load_error pulses once, time unchanged. Then load hours=24 -> same.
4. load_valid and sec_tick in the same cycle with time 10:10, loading 04:30 -> 04:30 after APPLY; no increment to 04:31.
5. alarm_set 07:00 with time 06:59, one sec_tick -> alarm_hit coincides with 07:00. Reloading 07:00 -> no hit. alarm_clear then count through 07:00 -> no hit.
6. Assert reset during APPLY of a valid load -> no error pulse; time=00:00; load_ready=1 the cycle after reset deasserts.
